buffer_packer: RTL

Read-side counterpart of the sample buffer writer. It walks a 24-bit sample memory from a start address and packs up to 32 samples per beat into a 768-bit word. The word is presented with a sample count over a valid/accept handshake, in the same MSB-first lane layout the writer consumes. It sits between the sample buffer's read port and the downstream transmit/processing FIFO.

---
 rtl/buffer_packer_pkg.sv | 20 ++
 rtl/buffer_packer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/buffer_packer_pkg.sv
`default_nettype none
// buffer_packer_pkg -- geometry and state encoding shared by the sample buffer writer and packer.
// Rev 1.0
package buffer_packer_pkg;

   localparam int SAMPLE_W = 24;
   localparam int LANES    = 32;
   localparam int DEPTH    = 3750;
   localparam int BEAT_W   = LANES * SAMPLE_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DRAIN   = 3'd2,
      PRESENT = 3'd3,
      FIN     = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/buffer_packer.sv
`default_nettype none
// buffer_packer -- reads a sample buffer from a start address and packs up to LANES samples per beat, MSB lane first.
// Rev 1.0
module buffer_packer
   import buffer_packer_pkg::*;
#(
   parameter int SAMPLE_W = buffer_packer_pkg::SAMPLE_W,
   parameter int LANES    = buffer_packer_pkg::LANES,
   parameter int DEPTH    = buffer_packer_pkg::DEPTH,
   parameter int ADDR_W   = 13
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic [ADDR_W-1:0]         total_len,
   output logic                      busy,
   output logic                      done,
   output logic                      mem_rd_en,
   output logic [ADDR_W-1:0]         mem_rd_addr,
   input  logic [SAMPLE_W-1:0]       mem_rd_data,
   output logic [LANES*SAMPLE_W-1:0] fifo_data,
   output logic [5:0]                num_samples,
   output logic                      data_ready,
   input  logic                      data_accept
);

   localparam int WORD_W = LANES * SAMPLE_W;
   localparam int LANE_W = 6;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] remaining;
   logic [ADDR_W-1:0] beat_n;
   logic [ADDR_W-1:0] len_clamped;
   logic [LANE_W-1:0] rd_idx;
   logic [LANE_W-1:0] cap_lane;
   logic              cap_valid;
   logic              last_rd;
   logic              accepted;

   assign len_clamped = (total_len > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : total_len;
   assign beat_n      = (remaining > ADDR_W'(LANES)) ? ADDR_W'(LANES) : remaining;
   assign last_rd     = (ADDR_W'(rd_idx) == beat_n - ADDR_W'(1));
   assign accepted    = (state == PRESENT) && data_accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      busy        = 1'b0;
      done        = 1'b0;
      mem_rd_en   = 1'b0;
      data_ready  = 1'b0;
      mem_rd_addr = addr;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = (len_clamped == '0) ? FIN : FETCH;
            end
         end
         FETCH: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            if (last_rd) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            busy     = 1'b1;
            state_nx = PRESENT;
         end
         PRESENT: begin
            busy       = 1'b1;
            data_ready = 1'b1;
            if (data_accept) begin
               state_nx = (remaining == beat_n) ? FIN : FETCH;
            end
         end
         FIN: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Read data returns one cycle after the strobe, so the lane index is delayed alongside it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr        <= '0;
         remaining   <= '0;
         rd_idx      <= '0;
         cap_lane    <= '0;
         cap_valid   <= 1'b0;
         fifo_data   <= '0;
         num_samples <= '0;
      end else begin
         cap_valid <= (state == FETCH);
         cap_lane  <= rd_idx;
         if (cap_valid) begin
            fifo_data[WORD_W-1-SAMPLE_W*int'(cap_lane) -: SAMPLE_W] <= mem_rd_data;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  addr      <= base_addr;
                  remaining <= len_clamped;
                  rd_idx    <= '0;
                  fifo_data <= '0;
               end
            end
            FETCH: begin
               num_samples <= beat_n[LANE_W-1:0];
               addr        <= (addr == ADDR_W'(DEPTH-1)) ? '0 : addr + ADDR_W'(1);
               rd_idx      <= last_rd ? '0 : rd_idx + LANE_W'(1);
            end
            PRESENT: begin
               if (accepted) begin
                  remaining <= remaining - beat_n;
                  fifo_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
